// File: rtl/alu_op_sequencer_if.sv
// Handshake and datapath bundle between the operation sequencer and its user/ALU.
// The master side issues operations and supplies the ALU result; the slave side is the sequencer.
interface alu_op_sequencer_if;
    logic        start;
    logic        abort;
    logic [4:0]  opcode;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [63:0] alu_result;
    logic [31:0] y_out;
    logic [31:0] b_out;
    logic [4:0]  alu_control;
    logic [31:0] z_hi;
    logic [31:0] z_lo;
    logic        busy;
    logic        done;
    logic        illegal;

    modport master (
        output start, abort, opcode, a_in, b_in, alu_result,
        input  y_out, b_out, alu_control, z_hi, z_lo, busy, done, illegal
    );

    modport slave (
        input  start, abort, opcode, a_in, b_in, alu_result,
        output y_out, b_out, alu_control, z_hi, z_lo, busy, done, illegal
    );
endinterface

// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: captures operands, waits a per-opcode number of
// EXEC cycles, latches the 64-bit ALU result and pulses done (or flags an illegal opcode).
module alu_op_sequencer #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 8
) (
    input logic                clock,
    input logic                clear,
    alu_op_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } state_t;

    localparam logic [4:0] OP_MUL  = 5'b01111;
    localparam logic [4:0] OP_DIV  = 5'b10000;
    localparam logic [4:0] OP_ZERO = 5'b11111;

    state_t      r_state;
    state_t      w_nextState;
    logic [31:0] r_y;
    logic [31:0] r_b;
    logic [31:0] r_zHi;
    logic [31:0] r_zLo;
    logic [4:0]  r_op;
    logic [3:0]  r_cnt;
    logic        r_illegal;

    logic        w_legal;
    logic        w_accept;
    logic [3:0]  w_loadCount;

    always_comb begin
        w_legal     = 1'b0;
        w_loadCount = 4'd0;
        case (bus.opcode)
            5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
            5'b01000, 5'b01001, 5'b01010, 5'b01011,
            5'b10001, 5'b10010, 5'b11111: w_legal = 1'b1;
            OP_MUL: begin
                w_legal     = 1'b1;
                w_loadCount = 4'(MUL_CYCLES - 1);
            end
            OP_DIV: begin
                w_legal     = 1'b1;
                w_loadCount = 4'(DIV_CYCLES - 1);
            end
            default: w_legal = 1'b0;
        endcase
    end

    // abort beats a simultaneous start in IDLE
    assign w_accept = bus.start & ~bus.abort;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState     = r_state;
        bus.busy        = 1'b0;
        bus.done        = 1'b0;
        bus.illegal     = 1'b0;
        bus.alu_control = OP_ZERO;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_nextState = w_legal ? EXEC : DONE;
                end
            end
            EXEC: begin
                bus.busy        = 1'b1;
                bus.alu_control = r_op;
                if (bus.abort) begin
                    w_nextState = IDLE;
                end else if (r_cnt == 4'd0) begin
                    w_nextState = DONE;
                end
            end
            DONE: begin
                bus.busy        = 1'b1;
                bus.done        = 1'b1;
                bus.illegal     = r_illegal;
                bus.alu_control = r_op;
                w_nextState     = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Illegal opcodes still record the opcode so alu_control shows it during DONE
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_y       <= 32'd0;
            r_b       <= 32'd0;
            r_zHi     <= 32'd0;
            r_zLo     <= 32'd0;
            r_op      <= OP_ZERO;
            r_cnt     <= 4'd0;
            r_illegal <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op      <= bus.opcode;
                        r_illegal <= ~w_legal;
                        if (w_legal) begin
                            r_y   <= bus.a_in;
                            r_b   <= bus.b_in;
                            r_cnt <= w_loadCount;
                        end else begin
                            r_zHi <= 32'd0;
                            r_zLo <= 32'd0;
                        end
                    end
                end
                EXEC: begin
                    if (!bus.abort) begin
                        if (r_cnt != 4'd0) begin
                            r_cnt <= r_cnt - 4'd1;
                        end else begin
                            r_zHi <= bus.alu_result[63:32];
                            r_zLo <= bus.alu_result[31:0];
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.y_out = r_y;
    assign bus.b_out = r_b;
    assign bus.z_hi  = r_zHi;
    assign bus.z_lo  = r_zLo;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized and directed bench for alu_op_sequencer, checked cycle by cycle against
// a transaction-level model that tracks elapsed cycles of the operation in flight.
module tb_alu_op_sequencer;

    localparam int MUL_CYCLES = 4;
    localparam int DIV_CYCLES = 8;

    logic clock = 1'b0;
    logic clear = 1'b0;

    always #5 clock = ~clock;

    alu_op_sequencer_if bus ();

    alu_op_sequencer #(
        .MUL_CYCLES(MUL_CYCLES),
        .DIV_CYCLES(DIV_CYCLES)
    ) dut (
        .clock(clock),
        .clear(clear),
        .bus  (bus)
    );

    int vectorsApplied = 0;
    int miscompares    = 0;
    int doneCount      = 0;

    // Model of the operation in flight
    bit          mActive;
    int          mElapsed;
    int          mW;
    logic [4:0]  mOp;
    logic        mIll;
    logic [31:0] mY, mB, mZHi, mZLo;

    logic [4:0] legalOps [14] = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111,
                                  5'b01000, 5'b01001, 5'b01010, 5'b01011, 5'b01111,
                                  5'b10000, 5'b10001, 5'b10010, 5'b11111};

    // Behavioural ALU: signed add/sub/mul/div, logical ops zero-extended
    function automatic logic [63:0] aluRef(input logic [4:0] op, input logic [31:0] y,
                                           input logic [31:0] b);
        logic signed [63:0] sy;
        logic signed [63:0] sb;
        logic signed [63:0] q;
        logic signed [63:0] rm;
        logic signed [31:0] y32;
        logic [63:0]        dbl;
        logic [4:0]         sh;
        sy  = $signed({{32{y[31]}}, y});
        sb  = $signed({{32{b[31]}}, b});
        y32 = $signed(y);
        sh  = b[4:0];
        case (op)
            5'b00011: return sy + sb;
            5'b00100: return sy - sb;
            5'b00101: return {32'd0, y >> sh};
            5'b00110: return {32'd0, 32'(y32 >>> sh)};
            5'b00111: return {32'd0, y << sh};
            5'b01000: begin
                dbl = {y, y} >> sh;
                return {32'd0, dbl[31:0]};
            end
            5'b01001: begin
                dbl = {y, y} << sh;
                return {32'd0, dbl[63:32]};
            end
            5'b01010: return {32'd0, y & b};
            5'b01011: return {32'd0, y | b};
            5'b01111: return sy * sb;
            5'b10000: begin
                if (b == 32'd0) return 64'd0;
                q  = sy / sb;
                rm = sy % sb;
                return {rm[31:0], q[31:0]};
            end
            5'b10001: return -sy;
            5'b10010: return {32'd0, ~y};
            default:  return 64'd0;
        endcase
    endfunction

    function automatic bit isLegal(input logic [4:0] op);
        foreach (legalOps[i]) if (legalOps[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int opCycles(input logic [4:0] op);
        if (op == 5'b01111) return MUL_CYCLES;
        if (op == 5'b10000) return DIV_CYCLES;
        return 1;
    endfunction

    assign bus.alu_result = aluRef(bus.alu_control, bus.y_out, bus.b_out);

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        vectorsApplied++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        mActive  = 1'b0;
        mElapsed = 0;
        mW       = 0;
        mOp      = 5'b11111;
        mIll     = 1'b0;
        mY       = 32'd0;
        mB       = 32'd0;
        mZHi     = 32'd0;
        mZLo     = 32'd0;
    endtask

    // Advance the model by one rising edge using the inputs presented for that edge
    task automatic modelEdge();
        if (!mActive) begin
            if (bus.start && !bus.abort) begin
                mActive  = 1'b1;
                mElapsed = 0;
                mOp      = bus.opcode;
                if (isLegal(bus.opcode)) begin
                    mIll = 1'b0;
                    mW   = opCycles(bus.opcode);
                    mY   = bus.a_in;
                    mB   = bus.b_in;
                end else begin
                    mIll = 1'b1;
                    mW   = 0;
                    mZHi = 32'd0;
                    mZLo = 32'd0;
                end
            end
        end else if (mElapsed < mW && bus.abort) begin
            mActive = 1'b0;
        end else begin
            mElapsed++;
            if (mElapsed == mW) {mZHi, mZLo} = aluRef(mOp, mY, mB);
            else if (mElapsed > mW) mActive = 1'b0;
        end
    endtask

    task automatic checkAll();
        logic eDone;
        eDone = mActive && (mElapsed == mW);
        if (bus.done === 1'b1) doneCount++;
        checkOutput("busy",        {63'd0, bus.busy},    {63'd0, mActive});
        checkOutput("done",        {63'd0, bus.done},    {63'd0, eDone});
        checkOutput("illegal",     {63'd0, bus.illegal}, {63'd0, eDone && mIll});
        checkOutput("alu_control", {59'd0, bus.alu_control}, {59'd0, mActive ? mOp : 5'b11111});
        checkOutput("y_out",       {32'd0, bus.y_out},   {32'd0, mY});
        checkOutput("b_out",       {32'd0, bus.b_out},   {32'd0, mB});
        checkOutput("z_hi",        {32'd0, bus.z_hi},    {32'd0, mZHi});
        checkOutput("z_lo",        {32'd0, bus.z_lo},    {32'd0, mZLo});
    endtask

    // Present inputs for one edge, then check outputs on the following falling edge
    task automatic applyStimulus(input logic s, input logic ab, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b);
        bus.start  = s;
        bus.abort  = ab;
        bus.opcode = op;
        bus.a_in   = a;
        bus.b_in   = b;
        @(posedge clock);
        modelEdge();
        @(negedge clock);
        checkAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, $urandom, $urandom);
    endtask

    // Asynchronous clear in the middle of the low clock phase
    task automatic pulseReset();
        #2 clear = 1'b0;
        #1 modelReset();
        checkAll();
        @(negedge clock);
        @(negedge clock);
        checkAll();
        clear = 1'b1;
    endtask

    initial begin
        int busyCycles;
        int doneAt;
        int doneBefore;
        logic [31:0] zHiAtDone;
        logic [31:0] zLoAtDone;
        logic [4:0]  op;

        bus.start  = 1'b0;
        bus.abort  = 1'b0;
        bus.opcode = 5'd0;
        bus.a_in   = 32'd0;
        bus.b_in   = 32'd0;
        modelReset();

        @(negedge clock);
        #1 checkAll();
        checkOutput("reset_ctrl", {59'd0, bus.alu_control}, 64'h1F);
        @(negedge clock);
        clear = 1'b1;

        // add 5+7, start accepted at the first edge after clear release
        applyStimulus(1'b1, 1'b0, 5'b00011, 32'd5, 32'd7);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        checkOutput("add_done", {63'd0, bus.done}, 64'd1);
        checkOutput("add_zlo",  {32'd0, bus.z_lo}, 64'd12);
        checkOutput("add_zhi",  {32'd0, bus.z_hi}, 64'd0);
        checkOutput("add_ill",  {63'd0, bus.illegal}, 64'd0);
        idleCycles(1);

        // mul -1 * 2: busy five cycles, done in the fifth
        applyStimulus(1'b1, 1'b0, 5'b01111, 32'hFFFF_FFFF, 32'd2);
        busyCycles = bus.busy ? 1 : 0;
        doneAt     = 0;
        zHiAtDone  = 32'd0;
        zLoAtDone  = 32'd0;
        for (int i = 2; i <= 7; i++) begin
            applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
            if (bus.busy) busyCycles++;
            if (bus.done) begin
                doneAt    = i;
                zHiAtDone = bus.z_hi;
                zLoAtDone = bus.z_lo;
            end
        end
        checkOutput("mul_busy_cycles", 64'(busyCycles), 64'd5);
        checkOutput("mul_done_cycle",  64'(doneAt), 64'd5);
        checkOutput("mul_zhi", {32'd0, zHiAtDone}, 64'hFFFF_FFFF);
        checkOutput("mul_zlo", {32'd0, zLoAtDone}, 64'hFFFF_FFFE);

        // illegal opcode: immediate done with illegal, operands untouched
        applyStimulus(1'b1, 1'b0, 5'b00000, 32'h1234_5678, 32'h9);
        checkOutput("ill_done", {63'd0, bus.done}, 64'd1);
        checkOutput("ill_flag", {63'd0, bus.illegal}, 64'd1);
        checkOutput("ill_y",    {32'd0, bus.y_out}, 64'hFFFF_FFFF);
        checkOutput("ill_z",    {bus.z_hi, bus.z_lo}, 64'd0);
        idleCycles(1);

        // div 100/7 with a start attempt during EXEC
        doneBefore = doneCount;
        applyStimulus(1'b1, 1'b0, 5'b10000, 32'd100, 32'd7);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        applyStimulus(1'b1, 1'b0, 5'b00011, 32'd1, 32'd1);
        idleCycles(10);
        checkOutput("div_done_pulses", 64'(doneCount - doneBefore), 64'd1);
        checkOutput("div_zlo", {32'd0, bus.z_lo}, 64'd14);
        checkOutput("div_zhi", {32'd0, bus.z_hi}, 64'd2);
        checkOutput("div_y",   {32'd0, bus.y_out}, 64'd100);

        // abort a mul in its second EXEC cycle
        doneBefore = doneCount;
        applyStimulus(1'b1, 1'b0, 5'b01111, 32'd3, 32'd3);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        applyStimulus(1'b0, 1'b1, 5'd0, 32'd0, 32'd0);
        checkOutput("abort_busy", {63'd0, bus.busy}, 64'd0);
        checkOutput("abort_ctrl", {59'd0, bus.alu_control}, 64'h1F);
        checkOutput("abort_zlo",  {32'd0, bus.z_lo}, 64'd14);
        idleCycles(6);
        checkOutput("abort_no_done", 64'(doneCount - doneBefore), 64'd0);

        // abort with start in IDLE is ignored
        applyStimulus(1'b1, 1'b1, 5'b00011, 32'd9, 32'd9);
        checkOutput("idle_abort_busy", {63'd0, bus.busy}, 64'd0);

        // clear during div EXEC, then a normal add straight after release
        applyStimulus(1'b1, 1'b0, 5'b10000, 32'd50, 32'd5);
        idleCycles(2);
        pulseReset();
        checkOutput("rst_z", {bus.z_hi, bus.z_lo}, 64'd0);
        checkOutput("rst_y", {32'd0, bus.y_out}, 64'd0);
        applyStimulus(1'b1, 1'b0, 5'b00011, 32'd20, 32'd22);
        applyStimulus(1'b0, 1'b0, 5'd0, 32'd0, 32'd0);
        checkOutput("post_rst_zlo", {32'd0, bus.z_lo}, 64'd42);

        // back-to-back adds with start held high
        for (int i = 0; i < 9; i++) applyStimulus(1'b1, 1'b0, 5'b00011, $urandom, $urandom);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                pulseReset();
            end else begin
                op = ($urandom_range(0, 7) == 0) ? 5'($urandom) : legalOps[$urandom_range(0, 13)];
                applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0, op,
                              $urandom, ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
